// File: rtl/ex_cnt_pkg.sv
// Shared definitions for the ex_cnt counter family: FSM state encoding and
// symbolic values for the direction and mode inputs.
package ex_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_e;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DN       = 1'b0;
  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/cnt_tick_gen.sv
// Clock-enable prescaler: while the gate is open it counts gated cycles and
// emits one tick every pre_div+1 of them. sync_clr restarts the prescale.
module cnt_tick_gen #(
  parameter int PRE_W = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             gate,
  input  logic             sync_clr,
  input  logic [PRE_W-1:0] pre_div,
  output logic             tick
);

  logic [PRE_W-1:0] r_pc;

  // The tick lands on the gated cycle where the phase counter reaches pre_div.
  assign tick = gate && (r_pc == pre_div);

  // Phase counter: cleared by sync_clr, frozen while the gate is closed.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst)           r_pc <= '0;
    else if (sync_clr) r_pc <= '0;
    else if (gate)     r_pc <= tick ? '0 : r_pc + 1'b1;
  end

endmodule

// File: rtl/mod_cnt.sv
// Modulo event/interval counter with programmable modulus, up/down direction,
// synchronous clear/load, prescaled count enable and a one-shot mode.
// Edge priority: rst > clr > load > start > count.
module mod_cnt
  import ex_cnt_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int PRE_W = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  input  logic [PRE_W-1:0] pre_div,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  cnt_state_e       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;

  logic             w_gate;
  logic             w_start;
  logic             w_sync_clr;
  logic             w_tick;
  logic             w_term;
  logic [WIDTH-1:0] w_load_sat;
  logic [WIDTH-1:0] w_wrap;

  // Continuous mode counts whenever enabled (this is also what lifts IDLE or
  // DONE into RUN); one-shot mode only counts inside RUN.
  assign w_gate     = en && ((mode == MODE_CONT) || (r_state == ST_RUN));
  // start is only honoured in one-shot mode and outside RUN.
  assign w_start    = (mode == MODE_ONESHOT) && start && (r_state != ST_RUN);
  assign w_sync_clr = clr || load || w_start;
  assign w_load_sat = (load_val > modulus) ? modulus : load_val;
  // Start preset and continuous wrap target share the same value.
  assign w_wrap     = (dir == DIR_UP) ? '0 : modulus;
  // Up uses >= so a modulus lowered below cnt ends the cycle on the next tick.
  assign w_term     = (dir == DIR_UP) ? (r_cnt >= modulus) : (r_cnt == '0);

  cnt_tick_gen #(.PRE_W(PRE_W)) u_tick (
    .sclk     (sclk),
    .rst      (rst),
    .gate     (w_gate),
    .sync_clr (w_sync_clr),
    .pre_div  (pre_div),
    .tick     (w_tick)
  );

  // FSM: clear to IDLE, start into RUN, terminal one-shot tick into DONE.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (clr) begin
      r_state <= ST_IDLE;
    end else if (load) begin
      r_state <= r_state;
    end else if (w_start) begin
      r_state <= ST_RUN;
    end else if (w_gate) begin
      if (mode == MODE_CONT)
        r_state <= ST_RUN;
      else if (w_tick && w_term)
        r_state <= ST_DONE;
    end
  end

  // Count datapath and terminal-count pulse; tc is a single-cycle strobe.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (clr) begin
        r_cnt <= '0;
      end else if (load) begin
        r_cnt <= w_load_sat;
      end else if (w_start) begin
        r_cnt <= w_wrap;
      end else if (w_gate && w_tick) begin
        if (w_term) begin
          r_tc <= 1'b1;
          // One-shot holds the terminal value; continuous wraps.
          if (mode == MODE_CONT) r_cnt <= w_wrap;
        end else if (dir == DIR_UP) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign cnt  = r_cnt;
  assign tc   = r_tc;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule
